axi_sram_slave: RTL
===================

// Module: axi_sram_slave
// PURPOSE
//   AXI4 slave wrapping an on-chip word RAM. It sits directly downstream of the CPU AXI master
//   interface and serves its AR/R/AW/W/B traffic, acting as the instruction/data memory.
//   It handles one transaction at a time with INCR bursts up to 256 beats.
//   It applies per-byte write strobes and arbitrates simultaneous read and write requests round-robin.
// PARAMETERS
//   ADDR_W   16  byte-address window width. RAM depth = 2^(ADDR_W-2) 32-bit words.
//   INIT_ZERO 1  1: RAM cleared at time 0 (simulation only). 0: contents undefined.
// PORTS
//   aclk     in   1   clock
//   aresetn  in   1   synchronous, active-low reset
//   arid     in   4   read ID; echoed on rid
//   araddr   in   32  read byte address
//   arlen    in   8   beats-1
//   arsize/arburst/arlock/arcache/arprot  in  3/2/2/4/3  ignored
//   arvalid  in   1   / arready out 1
//   rid      out  4   / rdata out 32 / rresp out 2 / rlast out 1 / rvalid out 1 / rready in 1
//   awid     in   4   write ID; echoed on bid
//   awaddr   in   32  / awlen in 8
//   awsize/awburst/awlock/awcache/awprot  in  3/2/2/4/3  ignored
//   awvalid  in   1   / awready out 1
//   wid      in   4   ignored
//   wdata    in   32  / wstrb in 4 / wlast in 1 / wvalid in 1 / wready out 1
//   bid      out  4   / bresp out 2 / bvalid out 1 / bready in 1
// BEHAVIOUR
// - Reset (aresetn low at an aclk edge):
//   - state=IDLE; last_was_wr=1.
//   - All valid/ready outputs are 0 while aresetn is low. rid/bid/rresp/bresp=0, rdata=0, rlast=0.
//   - RAM contents are preserved. A reset mid-burst abandons the transaction with no response.
// - FSM states: IDLE, RD_FETCH, RD_DATA, WR_DATA, WR_RESP.
// - IDLE arbitration (ready outputs are combinational from valids, IDLE only):
//   - grant_rd = arvalid & (!awvalid | last_was_wr); grant_wr = awvalid & !grant_rd.
//   - arready=grant_rd, awready=grant_wr. Read wins first after reset; types then alternate under contention.
// - Address capture on AR/AW handshake:
//   - Latch id, word index = addr[ADDR_W-1:2], beat counter = len.
//   - dec_err = |addr[31:ADDR_W], fixed for the whole burst. addr[1:0] ignored (word aligned).
//   - Set last_was_wr for the granted type. Next state: RD_FETCH or WR_DATA.
// - Read path:
//   - RD_FETCH: RAM read of the current index (1-cycle sync read).
//   - Next state RD_DATA: rvalid=1; rdata=RAM word, or 0 if dec_err; rresp=dec_err?2'b11:2'b00.
//   - rlast=(counter==0); rid=latched id.
//   - rdata/rresp/rlast are held stable while rvalid & !rready.
//   - On the R handshake:
//     - counter==0 -> IDLE.
//     - Otherwise index+1 (wraps modulo RAM depth), counter-1, -> RD_FETCH.
//   - Throughput is 1 beat per 2 cycles. AR handshake to first rvalid = 2 cycles.
// - Write path:
//   - WR_DATA: wready=1 (wready=0 in every other state, so early W data waits).
//   - Each W handshake:
//     - Writes byte lane i of RAM[index] iff wstrb[i] and !dec_err.
//     - If wlast != (counter==0), sets a sticky proto_err.
//     - counter==0 -> WR_RESP; else index+1 (wraps), counter-1.
//   - The beat count comes from awlen only; wlast never ends a burst.
//   - WR_RESP: bvalid=1, bid=latched id.
//     - bresp: 2'b11 if dec_err; else 2'b10 if proto_err; else 2'b00.
//     - Held until bready. Then -> IDLE and proto_err cleared.
// - Reads and writes never overlap. A read issued after a write's B handshake returns the new data.
// TESTING
// - Reset: aresetn=0 for 3 cycles with arvalid=awvalid=1 -> all valid/ready=0.
//   - First cycle after release: arready=1, awready=0.
// - Write 0x10 <- 0xDEADBEEF (awlen 0, wstrb 4'hF, awid 3) -> bvalid, bid=3, bresp=0.
//   - Then read 0x10 (arid 5) -> rdata=0xDEADBEEF, rid=5, rlast=1, rresp=0.
// - Byte strobe: write 0x10 data 0x0000AA00, wstrb 4'b0010 -> read 0x10 returns 0xDEADAAEF.
// - Burst: write 4 beats 1,2,3,4 at 0x20.
//   - Read arlen=3 with rready toggling 1/0 -> beats 1,2,3,4 in order.
//   - Data is stable across stalls; rlast only on beat 4.
// - Contention: arvalid & awvalid together after reset -> read served first, then write.
//   - Next simultaneous pair -> read again (last_was_wr=1).
// - Errors (ADDR_W=16):
//   - Read 0x0001_0000 -> rresp=2'b11, rdata=0.
//   - Write 0x0001_0000 -> bresp=2'b11, RAM unchanged.
//   - awlen=1 with wlast=1 on beat 0 -> both beats written, bresp=2'b10.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a single-port word RAM: one transaction at a time, INCR bursts,
// byte strobes, and round-robin choice between simultaneous read and write requests.
module axi_sram_slave #(
  parameter int ADDR_W    = 16,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [2:0] {IDLE, RD_FETCH, RD_DATA, WR_DATA, WR_RESP} state_t;

  state_t            state_reg, state_next;
  logic              last_was_wr_reg;
  logic [3:0]        id_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [7:0]        cnt_reg;
  logic              dec_err_reg;
  logic              proto_err_reg;
  logic [31:0]       ram_q;

  logic              grant_rd, grant_wr;
  logic              ram_re, ram_we;
  logic              last_beat;
  logic              beat_done;
  logic [31:0]       cap_addr;
  logic [3:0]        lane_we;

  assign last_beat = (cnt_reg == 8'd0);
  assign cap_addr  = grant_rd ? araddr : awaddr;
  assign beat_done = (rvalid & rready) | (wready & wvalid);

  // Every handshake output is forced low while aresetn is asserted, even before the first edge.
  always_comb begin
    state_next = state_reg;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    arready    = 1'b0;
    awready    = 1'b0;
    rvalid     = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    if (aresetn) begin
      case (state_reg)
        IDLE: begin
          grant_rd = arvalid & (~awvalid | last_was_wr_reg);
          grant_wr = awvalid & ~grant_rd;
          arready  = grant_rd;
          awready  = grant_wr;
          if (grant_rd)      state_next = RD_FETCH;
          else if (grant_wr) state_next = WR_DATA;
        end
        RD_FETCH: begin
          ram_re     = 1'b1;
          state_next = RD_DATA;
        end
        RD_DATA: begin
          rvalid = 1'b1;
          if (rready) state_next = last_beat ? IDLE : RD_FETCH;
        end
        WR_DATA: begin
          wready = 1'b1;
          if (wvalid) begin
            ram_we = ~dec_err_reg;
            if (last_beat) state_next = WR_RESP;
          end
        end
        WR_RESP: begin
          bvalid = 1'b1;
          if (bready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      last_was_wr_reg <= 1'b1;
      proto_err_reg   <= 1'b0;
      id_reg          <= '0;
      idx_reg         <= '0;
      cnt_reg         <= '0;
      dec_err_reg     <= 1'b0;
    end else begin
      if (grant_rd | grant_wr) begin
        id_reg          <= grant_rd ? arid : awid;
        idx_reg         <= cap_addr[ADDR_W-1:2];
        cnt_reg         <= grant_rd ? arlen : awlen;
        dec_err_reg     <= |cap_addr[31:ADDR_W];
        last_was_wr_reg <= grant_wr;
      end
      if (beat_done && !last_beat) begin
        idx_reg <= idx_reg + IDX_W'(1);
        cnt_reg <= cnt_reg - 8'd1;
      end
      // wlast only flags a mismatch; the burst length always comes from awlen.
      if (wready && wvalid && (wlast != last_beat)) proto_err_reg <= 1'b1;
      if (bvalid && bready) proto_err_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_we[gi] = ram_we & wstrb[gi];
  end

  if (INIT_ZERO) begin : g_ram_zero
    logic [31:0] mem [DEPTH] = '{default: 32'h0};
    always_ff @(posedge aclk) begin
      for (int i = 0; i < 4; i++)
        if (lane_we[i]) mem[idx_reg][i*8 +: 8] <= wdata[i*8 +: 8];
      if (ram_re) ram_q <= mem[idx_reg];
    end
  end else begin : g_ram
    logic [31:0] mem [DEPTH];
    always_ff @(posedge aclk) begin
      for (int i = 0; i < 4; i++)
        if (lane_we[i]) mem[idx_reg][i*8 +: 8] <= wdata[i*8 +: 8];
      if (ram_re) ram_q <= mem[idx_reg];
    end
  end

  // ram_q only reloads in RD_FETCH, so the beat stays stable through R stalls.
  assign rid   = rvalid ? id_reg : 4'd0;
  assign rdata = (rvalid && !dec_err_reg) ? ram_q : 32'h0;
  assign rresp = (rvalid && dec_err_reg) ? 2'b11 : 2'b00;
  assign rlast = rvalid & last_beat;
  assign bid   = bvalid ? id_reg : 4'd0;
  assign bresp = !bvalid ? 2'b00 : dec_err_reg ? 2'b11 : proto_err_reg ? 2'b10 : 2'b00;

  logic unused_ok;
  assign unused_ok = ^{arsize, arburst, arlock, arcache, arprot,
                       awsize, awburst, awlock, awcache, awprot, wid, cap_addr[1:0]};
endmodule
